ram_result_writer: RTL
======================

// Module: ram_result_writer
// PURPOSE
//   Back end of the brightness-filter datapath. Accepts packed DEPTH-lane result blocks from the
//   systolic array (PE_DATA_WIDTH bits per lane), narrows each lane to RAM_DATA_WIDTH, and writes
//   the lanes sequentially into the output RAM. Mirrors the input-side loader, which unpacks RAM
//   bytes into PE blocks. Fills 2**RAM_ADDR_WIDTH bytes, then pulses done.
// PARAMETERS
//   RAM_ADDR_WIDTH  6   output RAM address width (64 bytes)
//   RAM_DATA_WIDTH  8   output RAM word width
//   PE_DATA_WIDTH   16  width of one PE result lane
//   DEPTH           4   lanes per block (systolic array width); must divide 2**RAM_ADDR_WIDTH
// PORTS
//   clk          in   1                      system clock, rising edge
//   reset        in   1                      synchronous, active-high reset
//   start        in   1                      arm a new frame; sampled only in IDLE
//   data_in      in   PE_DATA_WIDTH*DEPTH    packed block; lane i = bits [i*PE_DATA_WIDTH +: PE_DATA_WIDTH]
//   data_valid   in   1                      data_in holds a valid block
//   data_ready   out  1                      block accepted on the cycle where valid && ready
//   ram_address  out  RAM_ADDR_WIDTH         RAM write address
//   ram_data     out  RAM_DATA_WIDTH         RAM write data
//   ram_wren     out  1                      RAM write enable (one byte per cycle)
//   busy         out  1                      high in every state except IDLE
//   done         out  1                      one-cycle pulse after the last byte is written
// BEHAVIOUR
//   Reset (sync): state=IDLE, base_addr=0, lane=0, buffer=0; data_ready=0, ram_wren=0,
//     ram_address=0, ram_data=0, busy=0, done=0. A reset mid-frame aborts the frame; no further
//     writes are issued and the partial frame is not completed.
//   FSM: IDLE -> ACCEPT on start (base_addr<=0). ACCEPT -> WRITE on valid&&ready (capture all
//     lanes, lane<=0). WRITE stays for DEPTH cycles: lane 0..DEPTH-1.
//     After lane DEPTH-1: base_addr += DEPTH; if the old base_addr == 2**RAM_ADDR_WIDTH-DEPTH
//     -> DONE_ST, else -> ACCEPT. DONE_ST -> IDLE unconditionally.
//   Outputs by state:
//     data_ready = (state==ACCEPT), combinational from state; independent of data_valid.
//     In WRITE: ram_wren=1, ram_address=base_addr+lane, ram_data=narrow(buffer[lane]).
//     Outside WRITE: ram_wren=0, ram_address=0, ram_data=0.
//     done=1 only during DONE_ST, which lasts one cycle.
//   Timing: block accepted in cycle T -> writes in cycles T+1..T+DEPTH (lane order 0..DEPTH-1)
//     -> data_ready high again in T+DEPTH+1. Peak throughput: 1 block per DEPTH+1 cycles.
//   data_valid while not ready: ignored, not queued. The producer holds data until the handshake.
//   start outside IDLE is ignored. start asserted in the DONE_ST cycle is ignored.
//   Address arithmetic is RAM_ADDR_WIDTH wide; the final block ends at address 2**RAM_ADDR_WIDTH-1
//     and never wraps.
// CONFIGURATION
//   RAM_WRITER_SATURATE_EN defined: narrow(x) = (x > 2**RAM_DATA_WIDTH-1) ? all-ones : x[RAM_DATA_WIDTH-1:0]
//     (unsigned clamp, e.g. 16'h012C -> 8'hFF).
//   Undefined: narrow(x) = x[RAM_DATA_WIDTH-1:0] (truncation, e.g. 16'h012C -> 8'h2C).
// STRUCTURE
//   systolic_pkg: state enum (IDLE, ACCEPT, WRITE, DONE_ST) as typedef writer_state_t;
//     shared RAM_ADDR_WIDTH/RAM_DATA_WIDTH/PE_DATA_WIDTH/DEPTH defaults as localparams.
//   Sub-module pe_lane_narrow: combinational PE_DATA_WIDTH -> RAM_DATA_WIDTH narrowing,
//     holds the RAM_WRITER_SATURATE_EN branch. The FSM, counters and lane buffer stay in this module.
//   The output RAM (write port) is instantiated by the parent, not inside this block.
// TESTING
//   1. Reset, then start, then 16 blocks with lane values {i*4+3, i*4+2, i*4+1, i*4} for block i
//      -> addresses 0..63 receive bytes 0..63 in order; done pulses once, exactly 1 cycle after
//      the write to address 63.
//   2. Block {16'h0000, 16'h00FF, 16'h0100, 16'h012C} (lanes 3..0):
//      SATURATE_EN -> bytes FF,FF,FF,00; without -> 2C,00,FF,00.
//   3. data_valid held high continuously -> data_ready high 1 cycle in every 5; no byte is
//      duplicated or dropped; 64 writes total.
//   4. Assert reset during the 2nd write of block 5 -> ram_wren=0 the next cycle, all outputs
//      reset, done never pulses; a fresh start rewrites the frame from address 0.
//   5. start pulsed during WRITE and during DONE_ST -> no effect; FSM returns to IDLE and busy=0
//      after done.
//   6. data_valid low for 10 cycles in ACCEPT -> data_ready stays 1, ram_wren stays 0,
//      base_addr unchanged.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and default sizes for the brightness-filter datapath.
// Writer FSM states live here so the loader and writer can share them.
package systolic_pkg;

  localparam int DEF_RAM_ADDR_WIDTH = 6;
  localparam int DEF_RAM_DATA_WIDTH = 8;
  localparam int DEF_PE_DATA_WIDTH  = 16;
  localparam int DEF_DEPTH          = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    WRITE,
    DONE_ST
  } writer_state_t;

endpackage

// File: rtl/pe_lane_narrow.sv
// Narrows one PE result lane to a RAM byte.
// RAM_WRITER_SATURATE_EN selects unsigned clamping instead of truncation.
module pe_lane_narrow #(
  parameter int PE_DATA_WIDTH  = 16,
  parameter int RAM_DATA_WIDTH = 8
) (
  input  logic [PE_DATA_WIDTH-1:0]  pe_data,
  output logic [RAM_DATA_WIDTH-1:0] ram_data
);

`ifdef RAM_WRITER_SATURATE_EN
  localparam logic [PE_DATA_WIDTH-1:0] MAX_VAL =
    {{(PE_DATA_WIDTH-RAM_DATA_WIDTH){1'b0}},
     {RAM_DATA_WIDTH{1'b1}}};

  assign ram_data = (pe_data > MAX_VAL)
                  ? {RAM_DATA_WIDTH{1'b1}}
                  : pe_data[RAM_DATA_WIDTH-1:0];
`else
  logic unused_hi;

  // Upper bits are dropped on purpose when truncating
  assign unused_hi = ^pe_data[PE_DATA_WIDTH-1:RAM_DATA_WIDTH];
  assign ram_data  = pe_data[RAM_DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/ram_result_writer.sv
// Unpacks PE result blocks lane by lane into the output RAM.
// Lane narrowing mode follows RAM_WRITER_SATURATE_EN (see pe_lane_narrow).
module ram_result_writer
  import systolic_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = DEF_RAM_ADDR_WIDTH,
  parameter int RAM_DATA_WIDTH = DEF_RAM_DATA_WIDTH,
  parameter int PE_DATA_WIDTH  = DEF_PE_DATA_WIDTH,
  parameter int DEPTH          = DEF_DEPTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [PE_DATA_WIDTH*DEPTH-1:0]  data_in,
  input  logic                            data_valid,
  output logic                            data_ready,
  output logic [RAM_ADDR_WIDTH-1:0]       ram_address,
  output logic [RAM_DATA_WIDTH-1:0]       ram_data,
  output logic                            ram_wren,
  output logic                            busy,
  output logic                            done
);

  localparam int LW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [RAM_ADDR_WIDTH-1:0] LAST_BASE =
    RAM_ADDR_WIDTH'(2**RAM_ADDR_WIDTH - DEPTH);
  localparam logic [RAM_ADDR_WIDTH-1:0] STEP =
    RAM_ADDR_WIDTH'(DEPTH);
  localparam logic [LW-1:0] LAST_LANE = LW'(DEPTH-1);

  writer_state_t             state;
  logic [RAM_ADDR_WIDTH-1:0] base_addr;
  logic [LW-1:0]             lane;
  logic [PE_DATA_WIDTH-1:0]  buffer [DEPTH];
  logic [RAM_DATA_WIDTH-1:0] lane_byte;
  logic                      in_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      base_addr <= '0;
      lane      <= '0;
      for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= ACCEPT;
            base_addr <= '0;
          end
        end
        ACCEPT: begin
          if (data_valid) begin
            state <= WRITE;
            lane  <= '0;
            for (int i = 0; i < DEPTH; i++)
              buffer[i] <= data_in[i*PE_DATA_WIDTH +: PE_DATA_WIDTH];
          end
        end
        WRITE: begin
          if (lane == LAST_LANE) begin
            lane      <= '0;
            base_addr <= base_addr + STEP;
            // Last block of the frame goes to DONE_ST, never wraps
            state     <= (base_addr == LAST_BASE) ? DONE_ST : ACCEPT;
          end else begin
            lane <= lane + 1'b1;
          end
        end
        DONE_ST: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  pe_lane_narrow #(
    .PE_DATA_WIDTH (PE_DATA_WIDTH),
    .RAM_DATA_WIDTH(RAM_DATA_WIDTH)
  ) u_narrow (
    .pe_data (buffer[lane]),
    .ram_data(lane_byte)
  );

  assign in_write    = (state == WRITE);
  assign data_ready  = (state == ACCEPT);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE_ST);
  assign ram_wren    = in_write;
  assign ram_address = in_write ? base_addr + RAM_ADDR_WIDTH'(lane) : '0;
  assign ram_data    = in_write ? lane_byte : '0;

endmodule
